// File: rtl/coo_adj_seq_if.sv
// ============================================================================
//  Module   : coo_adj_seq_if
//  Purpose  : Bundles the handshake and bus signals between the COO adjacency
//             sequencer, the FM*WM combination stage, the external COO address
//             counter and the aggregation buffer.
//  Ports    : master - sequencer side (drives coo_incr, wr_en, fm_wm_row,
//                      cnt_reset, ADJ_fm_wm_done)
//             slave  - environment side (drives done, coo_address, skip,
//                      wr_ready, restart)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface coo_adj_seq_if #(
  parameter int COO_BW = 3,
  parameter int ROW_BW = 1
);

  // Environment -> sequencer
  logic              done;
  logic [COO_BW-1:0] coo_address;
  logic              skip;
  logic              wr_ready;
  logic              restart;

  // Sequencer -> environment
  logic              coo_incr;
  logic              wr_en;
  logic [ROW_BW-1:0] fm_wm_row;
  logic              cnt_reset;
  logic              ADJ_fm_wm_done;

  modport master (
    input  done, coo_address, skip, wr_ready, restart,
    output coo_incr, wr_en, fm_wm_row, cnt_reset, ADJ_fm_wm_done
  );

  modport slave (
    output done, coo_address, skip, wr_ready, restart,
    input  coo_incr, wr_en, fm_wm_row, cnt_reset, ADJ_fm_wm_done
  );

endinterface

`default_nettype wire

// File: rtl/coo_adj_seq.sv
// ============================================================================
//  Module   : coo_adj_seq
//  Purpose  : Walks the COO adjacency list and sequences FM*WM row transfers
//             into the aggregation buffer. Each COO column entry issues one
//             to COO_NUM_OF_ROWS row writes; a skip in the write phase ends
//             the entry early. Supports write backpressure and restart.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous, active-low reset
//             bus    - coo_adj_seq_if.master
//                      in : done, coo_address, skip, wr_ready, restart
//                      out: coo_incr, wr_en, fm_wm_row, cnt_reset,
//                           ADJ_fm_wm_done
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coo_adj_seq #(
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_NUM_OF_ROWS = 2,
  parameter int COO_BW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1,
  parameter int ROW_BW = (COO_NUM_OF_ROWS > 1) ? $clog2(COO_NUM_OF_ROWS) : 1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  coo_adj_seq_if.master       bus
);

  localparam logic [COO_BW-1:0] LAST_COL = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [ROW_BW-1:0] LAST_ROW = ROW_BW'(COO_NUM_OF_ROWS - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ROW_BW-1:0] row;
  logic [ROW_BW-1:0] row_nxt;

  logic              coo_incr;
  logic              wr_en;
  logic [ROW_BW-1:0] fm_wm_row;
  logic              cnt_reset;
  logic              adj_done;
  logic              entry_end;

  // --------------------------------------------------------------------------
  // State and row registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_START;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    coo_incr  = 1'b0;
    wr_en     = 1'b0;
    fm_wm_row = '0;
    cnt_reset = 1'b0;
    adj_done  = 1'b0;
    // An entry finishes on an explicit skip or after its last possible row.
    entry_end = bus.skip || (row == LAST_ROW);

    case (state)
      ST_START: begin
        cnt_reset = 1'b1;
        if (bus.done) begin
          state_nxt = ST_READ;
          row_nxt   = '0;
        end
      end

      ST_READ: begin
        // Strobe is held until the buffer accepts it.
        wr_en     = 1'b1;
        fm_wm_row = row;
        if (bus.wr_ready) begin
          state_nxt = ST_WRITE;
        end
      end

      ST_WRITE: begin
        fm_wm_row = row;
        if (entry_end) begin
          // Addresses past the last entry are treated as the last entry so a
          // runaway counter cannot keep the pass alive.
          if (bus.coo_address >= LAST_COL) begin
            state_nxt = ST_DONE;
          end else begin
            coo_incr  = 1'b1;
            row_nxt   = '0;
            state_nxt = ST_READ;
          end
        end else begin
          row_nxt   = row + ROW_BW'(1);
          state_nxt = ST_READ;
        end
      end

      ST_DONE: begin
        adj_done = 1'b1;
        if (bus.restart) begin
          state_nxt = ST_START;
        end
      end

      default: begin
        state_nxt = ST_START;
        row_nxt   = '0;
      end
    endcase
  end

  assign bus.coo_incr       = coo_incr;
  assign bus.wr_en          = wr_en;
  assign bus.fm_wm_row      = fm_wm_row;
  assign bus.cnt_reset      = cnt_reset;
  assign bus.ADJ_fm_wm_done = adj_done;

endmodule

`default_nettype wire
